// File: rtl/arp_tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// arp_tx_framer_pkg
// Shared constants, FSM state type and small helpers for the ARP TX framer.
// No ports; imported by the framer.
// -----------------------------------------------------------------------------
package arp_tx_framer_pkg;

    // Ethernet / ARP header field values (network byte order, MSB first)
    localparam logic [15:0] ETHERTYPE_ARP   = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  ARP_HLEN_ETH    = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IPV4   = 8'h04;
    localparam logic [15:0] ARP_OP_REQUEST  = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY    = 16'h0002;
    localparam logic [47:0] MAC_BROADCAST   = 48'hFFFF_FFFF_FFFF;

    // Frame sizes in bytes: minimum Ethernet payload-padded frame (no FCS)
    // and the bare Ethernet + ARP header length.
    localparam int unsigned MIN_FRAME_BYTES = 32'd60;
    localparam int unsigned ARP_FRAME_BYTES = 32'd42;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_DONE = 2'b10
    } fsm_state_e;

    // Reorder an 8-byte big-endian chunk (first wire byte in bits 63:56)
    // into AXI-Stream lane order (first wire byte in bits 7:0).
    function automatic logic [63:0] wire_order(input logic [63:0] be_word);
        logic [63:0] r;
        r = 64'd0;
        for (int unsigned j = 0; j < 32'd8; j++) begin
            r[8*j +: 8] = be_word[63 - 8*j -: 8];
        end
        return r;
    endfunction

    // tkeep mask with the lowest nbytes lanes enabled.
    function automatic logic [7:0] keep_mask(input int unsigned nbytes);
        logic [7:0] m;
        m = 8'h00;
        for (int unsigned j = 0; j < 32'd8; j++) begin
            m[j] = (j < nbytes);
        end
        return m;
    endfunction

endpackage

// File: rtl/arp_tx_framer_if.sv
// -----------------------------------------------------------------------------
// arp_tx_framer_if
// 64-bit AXI4-Stream link carrying ARP frames toward the TX arbiter/MAC.
//   tdata  : frame data, byte n of the beat on tdata[8n+7:8n]
//   tkeep  : byte enables
//   tvalid : beat valid
//   tlast  : last beat of frame
//   tready : downstream ready
// master = frame source, slave = frame sink.
// -----------------------------------------------------------------------------
interface arp_tx_framer_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/arp_tx_framer.sv
// -----------------------------------------------------------------------------
// arp_tx_framer
// Builds complete Ethernet/ARP request or reply frames on a 64-bit
// AXI4-Stream master. FCS is appended downstream.
//
// Parameters:
//   PAD_EN : 1 = pad to 60 bytes (8 beats), 0 = 42-byte frame (6 beats)
// Ports:
//   tx_axis_aclk     : clock
//   tx_axis_aresetn  : synchronous reset, active-low
//   arp_tx_axis      : AXI4-Stream master (tdata/tkeep/tvalid/tlast/tready)
//   dst_mac_addr     : peer MAC, MSB is first byte on the wire
//   src_mac_addr     : local MAC
//   dst_ip_addr      : peer/target IP
//   src_ip_addr      : local IP
//   arp_request_req  : pulse, send an ARP request
//   arp_request_ack  : one-cycle pulse after the request frame completes
//   arp_reply_req    : pulse, send an ARP reply
//   arp_reply_ack    : one-cycle pulse after the reply frame completes
// -----------------------------------------------------------------------------
module arp_tx_framer
    import arp_tx_framer_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input  logic                   tx_axis_aclk,
    input  logic                   tx_axis_aresetn,
    arp_tx_framer_if.master        arp_tx_axis,
    input  logic [47:0]            dst_mac_addr,
    input  logic [47:0]            src_mac_addr,
    input  logic [31:0]            dst_ip_addr,
    input  logic [31:0]            src_ip_addr,
    input  logic                   arp_request_req,
    output logic                   arp_request_ack,
    input  logic                   arp_reply_req,
    output logic                   arp_reply_ack
);

    localparam int unsigned FRAME_BYTES = PAD_EN ? MIN_FRAME_BYTES : ARP_FRAME_BYTES;
    localparam int unsigned NUM_BEATS   = (FRAME_BYTES + 32'd7) / 32'd8;
    localparam logic [2:0]  LAST_BEAT   = 3'(NUM_BEATS - 32'd1);
    localparam logic [7:0]  LAST_KEEP   = keep_mask(FRAME_BYTES - 32'd8 * (NUM_BEATS - 32'd1));

    // ---------------- registers ----------------
    fsm_state_e  state_r;
    logic [2:0]  beat_cnt_r;
    logic        is_reply_r;
    logic        req_pend_r;
    logic        rep_pend_r;
    logic [47:0] dst_mac_r;
    logic [47:0] src_mac_r;
    logic [31:0] dst_ip_r;
    logic [31:0] src_ip_r;
    logic [63:0] tdata_r;
    logic [7:0]  tkeep_r;
    logic        tvalid_r;
    logic        tlast_r;
    logic        req_ack_r;
    logic        rep_ack_r;

    // ---------------- next-state / combinational ----------------
    fsm_state_e  state_nxt_s;
    logic [2:0]  beat_cnt_nxt_s;
    logic        is_reply_nxt_s;
    logic        req_pend_nxt_s;
    logic        rep_pend_nxt_s;
    logic        capture_s;
    logic [63:0] tdata_nxt_s;
    logic [7:0]  tkeep_nxt_s;
    logic        tvalid_nxt_s;
    logic        tlast_nxt_s;
    logic        req_ack_nxt_s;
    logic        rep_ack_nxt_s;

    logic        req_any_s;
    logic        rep_any_s;
    logic        src_reply_s;
    logic [2:0]  beat_sel_s;
    logic [47:0] src_dst_mac_s;
    logic [47:0] src_src_mac_s;
    logic [31:0] src_dst_ip_s;
    logic [31:0] src_src_ip_s;
    logic [47:0] eth_dst_s;
    logic [47:0] tha_s;
    logic [15:0] oper_s;
    logic [335:0] hdr_s;
    logic [511:0] frame_s;
    logic [63:0] beat_be_s;
    logic [63:0] beat_data_s;
    logic [7:0]  beat_keep_s;

    // A pulse arriving in the same cycle counts as pending, so a request
    // seen at an idle edge launches beat 0 on that very edge.
    assign req_any_s = req_pend_r | arp_request_req;
    assign rep_any_s = rep_pend_r | arp_reply_req;

    // Select the field sources for the next beat: live inputs when launching
    // from IDLE (beat 0), captured copies while a frame is in flight.
    always_comb begin
        src_reply_s   = is_reply_r;
        beat_sel_s    = beat_cnt_r + 3'd1;
        src_dst_mac_s = dst_mac_r;
        src_src_mac_s = src_mac_r;
        src_dst_ip_s  = dst_ip_r;
        src_src_ip_s  = src_ip_r;
        if (state_r == ST_IDLE) begin
            src_reply_s   = rep_any_s;
            beat_sel_s    = 3'd0;
            src_dst_mac_s = dst_mac_addr;
            src_src_mac_s = src_mac_addr;
            src_dst_ip_s  = dst_ip_addr;
            src_src_ip_s  = src_ip_addr;
        end else begin
            src_reply_s   = is_reply_r;
        end
    end

    // Assemble the header in wire order and slice out the selected beat.
    always_comb begin
        eth_dst_s = src_reply_s ? src_dst_mac_s : MAC_BROADCAST;
        tha_s     = src_reply_s ? src_dst_mac_s : 48'h0000_0000_0000;
        oper_s    = src_reply_s ? ARP_OP_REPLY : ARP_OP_REQUEST;
        hdr_s     = {eth_dst_s, src_src_mac_s, ETHERTYPE_ARP,
                     ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN_ETH, ARP_PLEN_IPV4,
                     oper_s, src_src_mac_s, src_src_ip_s, tha_s, src_dst_ip_s};
        // Trailing zeros double as the pad bytes and the unused lanes
        // after the end of the frame.
        frame_s   = {hdr_s, 176'd0};
        case (beat_sel_s)
            3'd0:    beat_be_s = frame_s[511:448];
            3'd1:    beat_be_s = frame_s[447:384];
            3'd2:    beat_be_s = frame_s[383:320];
            3'd3:    beat_be_s = frame_s[319:256];
            3'd4:    beat_be_s = frame_s[255:192];
            3'd5:    beat_be_s = frame_s[191:128];
            3'd6:    beat_be_s = frame_s[127:64];
            3'd7:    beat_be_s = frame_s[63:0];
            default: beat_be_s = 64'd0;
        endcase
        beat_data_s = wire_order(beat_be_s);
        beat_keep_s = (beat_sel_s == LAST_BEAT) ? LAST_KEEP : 8'hFF;
    end

    // FSM next-state and next output/flag values.
    always_comb begin
        state_nxt_s    = state_r;
        beat_cnt_nxt_s = beat_cnt_r;
        is_reply_nxt_s = is_reply_r;
        req_pend_nxt_s = req_pend_r | arp_request_req;
        rep_pend_nxt_s = rep_pend_r | arp_reply_req;
        capture_s      = 1'b0;
        tdata_nxt_s    = tdata_r;
        tkeep_nxt_s    = tkeep_r;
        tvalid_nxt_s   = tvalid_r;
        tlast_nxt_s    = tlast_r;
        req_ack_nxt_s  = 1'b0;
        rep_ack_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (req_any_s || rep_any_s) begin
                    capture_s      = 1'b1;
                    // Reply wins; a simultaneous request stays pending.
                    is_reply_nxt_s = rep_any_s;
                    if (rep_any_s) begin
                        rep_pend_nxt_s = 1'b0;
                    end else begin
                        req_pend_nxt_s = 1'b0;
                    end
                    beat_cnt_nxt_s = 3'd0;
                    tdata_nxt_s    = beat_data_s;
                    tkeep_nxt_s    = beat_keep_s;
                    tvalid_nxt_s   = 1'b1;
                    tlast_nxt_s    = 1'b0;
                    state_nxt_s    = ST_SEND;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tvalid_r && arp_tx_axis.tready) begin
                    if (tlast_r) begin
                        tdata_nxt_s   = 64'd0;
                        tkeep_nxt_s   = 8'h00;
                        tvalid_nxt_s  = 1'b0;
                        tlast_nxt_s   = 1'b0;
                        req_ack_nxt_s = ~is_reply_r;
                        rep_ack_nxt_s = is_reply_r;
                        state_nxt_s   = ST_DONE;
                    end else begin
                        beat_cnt_nxt_s = beat_cnt_r + 3'd1;
                        tdata_nxt_s    = beat_data_s;
                        tkeep_nxt_s    = beat_keep_s;
                        tlast_nxt_s    = (beat_sel_s == LAST_BEAT);
                    end
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                tdata_nxt_s  = 64'd0;
                tkeep_nxt_s  = 8'h00;
                tvalid_nxt_s = 1'b0;
                tlast_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, flag, capture and output registers with synchronous reset.
    always_ff @(posedge tx_axis_aclk) begin
        if (!tx_axis_aresetn) begin
            state_r    <= ST_IDLE;
            beat_cnt_r <= 3'd0;
            is_reply_r <= 1'b0;
            req_pend_r <= 1'b0;
            rep_pend_r <= 1'b0;
            dst_mac_r  <= 48'd0;
            src_mac_r  <= 48'd0;
            dst_ip_r   <= 32'd0;
            src_ip_r   <= 32'd0;
            tdata_r    <= 64'd0;
            tkeep_r    <= 8'h00;
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            req_ack_r  <= 1'b0;
            rep_ack_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
            is_reply_r <= is_reply_nxt_s;
            req_pend_r <= req_pend_nxt_s;
            rep_pend_r <= rep_pend_nxt_s;
            tdata_r    <= tdata_nxt_s;
            tkeep_r    <= tkeep_nxt_s;
            tvalid_r   <= tvalid_nxt_s;
            tlast_r    <= tlast_nxt_s;
            req_ack_r  <= req_ack_nxt_s;
            rep_ack_r  <= rep_ack_nxt_s;
            if (capture_s) begin
                dst_mac_r <= dst_mac_addr;
                src_mac_r <= src_mac_addr;
                dst_ip_r  <= dst_ip_addr;
                src_ip_r  <= src_ip_addr;
            end else begin
                dst_mac_r <= dst_mac_r;
                src_mac_r <= src_mac_r;
                dst_ip_r  <= dst_ip_r;
                src_ip_r  <= src_ip_r;
            end
        end
    end

    assign arp_tx_axis.tdata  = tdata_r;
    assign arp_tx_axis.tkeep  = tkeep_r;
    assign arp_tx_axis.tvalid = tvalid_r;
    assign arp_tx_axis.tlast  = tlast_r;
    assign arp_request_ack    = req_ack_r;
    assign arp_reply_ack      = rep_ack_r;

endmodule

// File: tb/tb_arp_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_arp_tx_framer
// Drives a padded (PAD_EN=1) and an unpadded (PAD_EN=0) framer with the same
// requests. Expected frames are queued when requests are issued; a monitor
// on the falling edge rebuilds every beat byte-by-byte from the ARP field
// layout and compares it, plus handshake stability and ack timing.
// -----------------------------------------------------------------------------
module tb_arp_tx_framer;

    typedef struct {
        bit          is_reply;
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [31:0] dip;
        logic [31:0] sip;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        tready;
    logic [47:0] dst_mac, src_mac;
    logic [31:0] dst_ip, src_ip;
    logic        req_p, rep_p;
    logic        rq_ack_p, rp_ack_p, rq_ack_n, rp_ack_n;
    int          rmode;

    int          n_checks = 0;
    int          n_errors = 0;

    exp_t        expq[2][$];
    int          mbeat[2];
    logic [1:0]  ack_exp[2];
    bit          hold[2];
    logic [63:0] prev_td[2];
    logic [7:0]  prev_tk[2];
    logic        prev_tl[2];
    logic [63:0] cap[2][8];

    arp_tx_framer_if ifc_p ();
    arp_tx_framer_if ifc_n ();
    assign ifc_p.tready = tready;
    assign ifc_n.tready = tready;

    arp_tx_framer #(.PAD_EN(1'b1)) dut_p (
        .tx_axis_aclk    (clk),
        .tx_axis_aresetn (rst_n),
        .arp_tx_axis     (ifc_p),
        .dst_mac_addr    (dst_mac),
        .src_mac_addr    (src_mac),
        .dst_ip_addr     (dst_ip),
        .src_ip_addr     (src_ip),
        .arp_request_req (req_p),
        .arp_request_ack (rq_ack_p),
        .arp_reply_req   (rep_p),
        .arp_reply_ack   (rp_ack_p)
    );

    arp_tx_framer #(.PAD_EN(1'b0)) dut_n (
        .tx_axis_aclk    (clk),
        .tx_axis_aresetn (rst_n),
        .arp_tx_axis     (ifc_n),
        .dst_mac_addr    (dst_mac),
        .src_mac_addr    (src_mac),
        .dst_ip_addr     (dst_ip),
        .src_ip_addr     (src_ip),
        .arp_request_req (req_p),
        .arp_request_ack (rq_ack_n),
        .arp_reply_req   (rep_p),
        .arp_reply_ack   (rp_ack_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] field_byte(input logic [47:0] v, input int n, input int k);
        return v[8*(n-1-k) +: 8];
    endfunction

    function automatic logic [7:0] model_byte(input exp_t e, input int i);
        logic [47:0] eth_dst, tha;
        logic [47:0] op;
        eth_dst = e.is_reply ? e.dmac : 48'hFFFF_FFFF_FFFF;
        tha     = e.is_reply ? e.dmac : 48'h0;
        op      = e.is_reply ? 48'h0002 : 48'h0001;
        if (i < 6)        return field_byte(eth_dst, 6, i);
        else if (i < 12)  return field_byte(e.smac, 6, i - 6);
        else if (i < 14)  return field_byte(48'h0806, 2, i - 12);
        else if (i < 16)  return field_byte(48'h0001, 2, i - 14);
        else if (i < 18)  return field_byte(48'h0800, 2, i - 16);
        else if (i == 18) return 8'h06;
        else if (i == 19) return 8'h04;
        else if (i < 22)  return field_byte(op, 2, i - 20);
        else if (i < 28)  return field_byte(e.smac, 6, i - 22);
        else if (i < 32)  return field_byte({16'h0, e.sip}, 4, i - 28);
        else if (i < 38)  return field_byte(tha, 6, i - 32);
        else if (i < 42)  return field_byte({16'h0, e.dip}, 4, i - 38);
        else              return 8'h00;
    endfunction

    function automatic void model_beat(input exp_t e, input bit pad, input int b,
                                       output logic [63:0] d, output logic [7:0] k);
        int len;
        len = pad ? 60 : 42;
        d = 64'd0;
        k = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (8*b + j < len) begin
                k[j] = 1'b1;
                d[8*j +: 8] = model_byte(e, 8*b + j);
            end
        end
    endfunction

    // ---------------- monitor ----------------
    task automatic mon_step(input int id, input bit pad, input logic [63:0] td,
                            input logic [7:0] tk, input logic tv, input logic tl,
                            input logic rq_ack, input logic rp_ack);
        exp_t        e;
        logic [63:0] ed;
        logic [7:0]  ek;
        int          nb;
        if (rst_n !== 1'b1) begin
            mbeat[id]   = 0;
            ack_exp[id] = 2'b00;
            hold[id]    = 1'b0;
            return;
        end
        if (ack_exp[id] != 2'b00 || {rp_ack, rq_ack} !== 2'b00)
            chk($sformatf("ack_dut%0d", id), {rp_ack, rq_ack}, ack_exp[id]);
        ack_exp[id] = 2'b00;
        if (hold[id])
            chk($sformatf("stall_hold_dut%0d", id), {tv, tl, tk, td},
                {1'b1, prev_tl[id], prev_tk[id], prev_td[id]});
        if (tv === 1'b1) begin
            if (expq[id].size() == 0) begin
                chk($sformatf("unexpected_beat_dut%0d", id), expq[id].size(), 1);
            end else begin
                e  = expq[id][0];
                nb = pad ? 8 : 6;
                model_beat(e, pad, mbeat[id], ed, ek);
                chk($sformatf("beat%0d_dut%0d", mbeat[id], id), {tl, tk, td},
                    {(mbeat[id] == nb - 1), ek, ed});
                if (tready === 1'b1) begin
                    cap[id][mbeat[id]] = td;
                    if (mbeat[id] == nb - 1) begin
                        ack_exp[id] = e.is_reply ? 2'b10 : 2'b01;
                        void'(expq[id].pop_front());
                        mbeat[id] = 0;
                    end else begin
                        mbeat[id]++;
                    end
                end
            end
        end
        hold[id]    = (tv === 1'b1) && (tready === 1'b0);
        prev_td[id] = td;
        prev_tk[id] = tk;
        prev_tl[id] = tl;
    endtask

    always @(negedge clk) begin
        mon_step(0, 1'b1, ifc_p.tdata, ifc_p.tkeep, ifc_p.tvalid, ifc_p.tlast, rq_ack_p, rp_ack_p);
        mon_step(1, 1'b0, ifc_n.tdata, ifc_n.tkeep, ifc_n.tvalid, ifc_n.tlast, rq_ack_n, rp_ack_n);
    end

    // ---------------- tready generator ----------------
    initial begin
        logic [3:0] pat;
        int         ph;
        pat    = 4'b1001;
        ph     = 0;
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       begin tready = pat[ph]; ph = (ph + 1) % 4; end
                2:       tready = 1'($urandom_range(0, 1));
                default: tready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_exp(input bit rep);
        exp_t e;
        e.is_reply = rep;
        e.dmac = dst_mac;
        e.smac = src_mac;
        e.dip  = dst_ip;
        e.sip  = src_ip;
        expq[0].push_back(e);
        expq[1].push_back(e);
    endtask

    task automatic pulse(input bit rq, input bit rp, input bit chk_lat);
        @(posedge clk);
        #1;
        req_p = rq;
        rep_p = rp;
        @(posedge clk);
        #1;
        req_p = 1'b0;
        rep_p = 1'b0;
        if (chk_lat)
            chk("latency_tvalid", {ifc_p.tvalid, ifc_n.tvalid}, 2'b11);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((expq[0].size() != 0 || expq[1].size() != 0) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain", expq[0].size() + expq[1].size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_test_addrs();
        dst_mac = 48'hAC00_0124_25BC;
        src_mac = 48'hAB10_2027_55FC;
        dst_ip  = 32'hC0A8_010A;
        src_ip  = 32'hC0A8_010B;
    endtask

    task automatic rand_addrs();
        dst_mac = {16'($urandom), $urandom};
        src_mac = {16'($urandom), $urandom};
        dst_ip  = $urandom;
        src_ip  = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int c;
        int t;
        rst_n = 1'b0;
        req_p = 1'b0;
        rep_p = 1'b0;
        rmode = 0;
        set_test_addrs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_p", {ifc_p.tdata, ifc_p.tkeep, ifc_p.tvalid, ifc_p.tlast, rq_ack_p, rp_ack_p}, 0);
        chk("reset_out_n", {ifc_n.tdata, ifc_n.tkeep, ifc_n.tvalid, ifc_n.tlast, rq_ack_n, rp_ack_n}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // request, always ready
        push_exp(1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        wait_idle(200);
        chk("req_beat0", cap[0][0], 64'h10AB_FFFF_FFFF_FFFF);
        chk("req_beat1", cap[0][1], 64'h0100_0608_FC55_2720);
        chk("req_beat2", cap[0][2], 64'h10AB_0100_0406_0008);
        chk("nopad_beat5", cap[1][5], 64'h0000_0000_0000_0A01);

        // reply, always ready
        push_exp(1'b1);
        pulse(1'b0, 1'b1, 1'b1);
        wait_idle(200);
        chk("rep_beat0", cap[0][0], 64'h10AB_BC25_2401_00AC);
        chk("rep_beat2", cap[0][2], 64'h10AB_0200_0406_0008);
        chk("rep_beat4", cap[0][4], 64'hA8C0_BC25_2401_00AC);

        // backpressure 1,0,0,1 with addresses changing mid-frame
        rmode = 1;
        push_exp(1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        rand_addrs();
        wait_idle(400);
        rmode = 0;
        set_test_addrs();

        // simultaneous pulses: reply then request
        push_exp(1'b1);
        push_exp(1'b0);
        pulse(1'b1, 1'b1, 1'b1);
        wait_idle(400);

        // duplicate request pulses while busy collapse into one frame
        rmode = 2;
        push_exp(1'b1);
        push_exp(1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle(800);
        rmode = 0;

        // reset during beat 3 aborts the frame
        push_exp(1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        c = 0;
        while (mbeat[0] != 3 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("reached_beat3", mbeat[0], 3);
        rst_n = 1'b0;
        expq[0].delete();
        expq[1].delete();
        @(posedge clk);
        #1;
        chk("abort_outputs", {ifc_p.tvalid, ifc_n.tvalid, rq_ack_p, rp_ack_p, rq_ack_n, rp_ack_n}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push_exp(1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        wait_idle(200);

        // randomized frames with random backpressure
        rmode = 2;
        for (int i = 0; i < 20; i++) begin
            rand_addrs();
            t = $urandom_range(0, 2);
            if (t != 0) push_exp(1'b1);
            if (t != 1) push_exp(1'b0);
            pulse(t != 1, t != 0, 1'b1);
            wait_idle(1000);
        end
        rmode = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
